// File: rtl/instruction_sequencer.sv
// Instruction FIFO and issue sequencer for the 512-bit datapath.
// Holds each instruction for an opcode-dependent number of cycles.
module instruction_sequencer #(
  parameter int DEPTH      = 8,
  parameter int MEM_CYCLES = 1,
  parameter int ADD_CYCLES = 2,
  parameter int MUL_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [12:0]              in_instr,
  output logic                     in_ready,
  output logic [12:0]              instruction_Register,
  output logic                     issue,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MX1  = (ADD_CYCLES > MEM_CYCLES) ? ADD_CYCLES : MEM_CYCLES;
  localparam int MAXC = (MUL_CYCLES > MX1) ? MUL_CYCLES : MX1;
  localparam int RW   = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [RW-1:0]     remain, remain_n;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [12:0]       mem [DEPTH];
  logic [12:0]       head;
  logic              push, pop;
  logic              can_issue;

  function automatic logic [RW-1:0] occ_m1(input logic [1:0] op);
    logic [RW-1:0] r;
    unique case (op)
      2'b00:   r = RW'(MEM_CYCLES - 1);
      2'b01:   r = RW'(MEM_CYCLES - 1);
      2'b10:   r = RW'(ADD_CYCLES - 1);
      2'b11:   r = RW'(MUL_CYCLES - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign head      = mem[rd_ptr];
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign can_issue = run && (count != '0) && !flush;
  assign busy      = (state == EXEC);
  assign done      = (state == EXEC) && (remain == '0);

  // Next-state, occupancy countdown and pop decision
  always_comb begin
    state_n  = state;
    remain_n = remain;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_issue) begin
          pop      = 1'b1;
          state_n  = EXEC;
          remain_n = occ_m1(head[12:11]);
        end
      end
      EXEC: begin
        if (remain != '0) begin
          remain_n = remain - 1'b1;
        end else if (can_issue) begin
          pop      = 1'b1;
          remain_n = occ_m1(head[12:11]);
        end else begin
          state_n  = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        remain_n = '0;
      end
    endcase
  end

  // FSM state and countdown register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= state_n;
      remain <= remain_n;
    end
  end

  // Issued instruction and first-cycle strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction_Register <= 13'h0000;
      issue                <= 1'b0;
    end else begin
      issue <= pop;
      if (pop) begin
        instruction_Register <= head;
      end
    end
  end

  // FIFO storage; contents need no reset since count gates reads
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // FIFO pointers and occupancy; flush empties and drops any push
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer.
// Queue-based reference model plus directed literal checks.
module tb_instruction_sequencer;

  localparam int DEPTH = 8;
  localparam int MEMC  = 1;
  localparam int ADDC  = 2;
  localparam int MULC  = 4;

  logic        clock;
  logic        reset;
  logic        run;
  logic        flush;
  logic        in_valid;
  logic [12:0] in_instr;
  logic        in_ready;
  logic [12:0] instruction_Register;
  logic        issue;
  logic        busy;
  logic        done;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  instruction_sequencer #(
    .DEPTH(DEPTH), .MEM_CYCLES(MEMC),
    .ADD_CYCLES(ADDC), .MUL_CYCLES(MULC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .flush(flush),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .instruction_Register(instruction_Register),
    .issue(issue),
    .busy(busy),
    .done(done),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of waiting words and the executing word
  // with how many of its cycles have elapsed so far.
  logic [12:0] mq [$];
  logic [12:0] minstr = 13'h0;
  bit          mexec  = 1'b0;
  int          age    = 0;
  int          ncyc   = 0;

  function automatic int occ(input logic [12:0] w);
    if (w[12:11] == 2'b11) return MULC;
    if (w[12:11] == 2'b10) return ADDC;
    return MEMC;
  endfunction

  initial begin
    int sz;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq.delete();
        mexec  = 1'b0;
        age    = 0;
        ncyc   = 0;
        minstr = 13'h0;
      end else begin
        sz = mq.size();
        if (mexec && age < ncyc) begin
          age++;
        end else if (run && sz != 0 && !flush) begin
          minstr = mq.pop_front();
          ncyc   = occ(minstr);
          age    = 1;
          mexec  = 1'b1;
        end else begin
          mexec = 1'b0;
        end
        if (flush) mq.delete();
        else if (in_valid && sz < DEPTH) mq.push_back(in_instr);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (reset) begin
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("m_instr", 32'(instruction_Register), 32'(minstr));
      chk("m_busy", 32'(busy), 32'(mexec));
      chk("m_issue", 32'(issue), 32'(mexec && age == 1));
      chk("m_done", 32'(done), 32'(mexec && age == ncyc));
    end
  end

  // Capture of issued words for the ordering test
  bit          cap_en = 1'b0;
  logic [12:0] issued [$];
  always @(negedge clock) begin
    if (reset && cap_en && issue) issued.push_back(instruction_Register);
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy || count != 0) && n < maxc) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", 32'(busy || count != 0), 32'd0);
  endtask

  logic [7:0]  bv, iv, dv;
  logic [12:0] pushed [$];
  int          bad;

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = 13'h0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_instr", 32'(instruction_Register), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single ADD
    run      = 1'b1;
    in_valid = 1'b1;
    in_instr = 13'h1000;
    step();
    in_valid = 1'b0;
    chk("add_wait_busy", 32'(busy), 32'd0);
    step();
    chk("add_instr", 32'(instruction_Register), 32'h1000);
    chk("add_issue", 32'(issue), 32'd1);
    chk("add_busy1", 32'(busy), 32'd1);
    chk("add_done1", 32'(done), 32'd0);
    step();
    chk("add_busy2", 32'(busy), 32'd1);
    chk("add_done2", 32'(done), 32'd1);
    chk("add_issue2", 32'(issue), 32'd0);
    step();
    chk("add_idle", 32'(busy), 32'd0);

    // Back-to-back MUL, load, store
    run      = 1'b0;
    in_valid = 1'b1;
    in_instr = 13'h1A05;
    step();
    in_instr = 13'h0A10;
    step();
    in_instr = 13'h0203;
    step();
    in_valid = 1'b0;
    chk("b2b_count", 32'(count), 32'd3);
    run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      bv[c] = busy;
      iv[c] = issue;
      dv[c] = done;
      if (c == 4) chk("b2b_instr5", 32'(instruction_Register), 32'h0A10);
      if (c == 5) chk("b2b_instr6", 32'(instruction_Register), 32'h0203);
    end
    chk("b2b_busy", 32'(bv), 32'h3F);
    chk("b2b_issue", 32'(iv), 32'h31);
    chk("b2b_done", 32'(dv), 32'h38);

    // Back-pressure
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = 13'h0100 + 13'(i);
      chk("bp_in_ready", 32'(in_ready), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) step();
    end
    chk("bp_count_full", 32'(count), 32'd8);
    run = 1'b1;
    step();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_count_after_pop", 32'(count), 32'd7);
    step();
    in_valid = 1'b0;
    chk("bp_count_9th", 32'(count), 32'd7);
    wait_idle(30);

    // Flush during a MUL
    run      = 1'b0;
    in_valid = 1'b1;
    in_instr = 13'h1801;
    step();
    for (int i = 0; i < 3; i++) begin
      in_instr = 13'h0011 + 13'(i);
      step();
    end
    in_valid = 1'b0;
    run = 1'b1;
    step();
    chk("fl_issue", 32'(issue), 32'd1);
    chk("fl_count_q", 32'(count), 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_busy3", 32'(busy), 32'd1);
    step();
    chk("fl_done4", 32'(done), 32'd1);
    chk("fl_instr", 32'(instruction_Register), 32'h1801);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (issue || busy) bad++;
    end
    chk("fl_no_issue", 32'(bad), 32'd0);

    // Wrap-around ordering with continuous push and pop
    issued.delete();
    pushed.delete();
    cap_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_instr = 13'h0040 + 13'(i);
      pushed.push_back(in_instr);
      step();
    end
    in_valid = 1'b0;
    wait_idle(15);
    cap_en = 1'b0;
    chk("wrap_size", 32'(issued.size()), 32'd20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= issued.size() || issued[i] !== pushed[i]) bad++;
    end
    chk("wrap_order", 32'(bad), 32'd0);

    // Asynchronous reset mid-MUL with three words queued
    run      = 1'b0;
    in_valid = 1'b1;
    in_instr = 13'h1801;
    step();
    for (int i = 0; i < 3; i++) begin
      in_instr = 13'h0001 + 13'(i);
      step();
    end
    in_valid = 1'b0;
    run = 1'b1;
    step();
    chk("rm_count3", 32'(count), 32'd3);
    chk("rm_busy", 32'(busy), 32'd1);
    step();
    #2 reset = 1'b0;
    #1;
    chk("ar_instr", 32'(instruction_Register), 32'h0);
    chk("ar_issue", 32'(issue), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("ar_rel_count", 32'(count), 32'd0);
    chk("ar_rel_ready", 32'(in_ready), 32'd1);
    chk("ar_rel_busy", 32'(busy), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
